// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - command FIFO, issue stage and response register in front of the combinational alu
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op, cmd_a, cmd_b, cmd_acc   command fields; cmd_acc selects acc as operand A at issue
//   alu_op, alu_a, alu_b            drive the external alu from the FIFO head (0 when empty)
//   alu_result, alu_carry           combinational alu outputs, captured on issue
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_carry,
//   rsp_zero, rsp_neg               registered response data and flags
//   acc                             result of the most recently issued command
//   count                           FIFO occupancy, 0..DEPTH

module alu_issue #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [7:0]    cmd_a,
    input  logic [7:0]    cmd_b,
    input  logic          cmd_acc,
    output logic [2:0]    alu_op,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    input  logic [7:0]    alu_result,
    input  logic          alu_carry,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_result,
    output logic          rsp_carry,
    output logic          rsp_zero,
    output logic          rsp_neg,
    output logic [7:0]    acc,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_COUNT  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR    = AW'(1);

    // entry layout: {acc_sel, op[2:0], a[7:0], b[7:0]}
    typedef struct packed {
        logic       acc_sel;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_entry_t;

    cmd_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    cmd_entry_t    head;
    logic          push;
    logic          issue;
    logic          not_empty;

    // cmd_ready looks only at stored occupancy, so a full FIFO refuses a
    // command even in a cycle where the head is being issued.
    assign cmd_ready = (count < FULL_COUNT);
    assign not_empty = (count != '0);
    assign push      = cmd_valid && cmd_ready;
    assign issue     = not_empty && (!rsp_valid || rsp_ready);
    assign head      = mem[rd_ptr];

    always_comb begin
        alu_op = 3'd0;
        alu_a  = 8'd0;
        alu_b  = 8'd0;
        if (not_empty) begin
            alu_op = head.op;
            alu_b  = head.b;
            alu_a  = head.acc_sel ? acc : head.a;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{acc_sel: cmd_acc, op: cmd_op, a: cmd_a, b: cmd_b};
                wr_ptr      <= wr_ptr + ONE_PTR;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({push, issue})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

    // Response register and accumulator. acc loads on the issue edge itself
    // so a following cmd_acc command sees it with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= 8'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_neg    <= 1'b0;
            acc        <= 8'd0;
        end else if (issue) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= (alu_result == 8'd0);
            rsp_neg    <= alu_result[7];
            acc        <= alu_result;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Command front-end for the 8-bit combinational `alu`. Accepts `{op, a, b}` commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Issues one command per cycle to the ALU and registers the ALU result, carry and derived flags into a response register with its own valid/ready handshake. Also keeps an accumulator holding the last issued result, so chained operations can use it as operand A without a software round trip.

## Interface
- `DEPTH`, default 4: command FIFO entries; a power of two, ≥ 2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: a command is presented.
- `cmd_ready`, output, 1: FIFO can accept a command.
- `cmd_op`, input, 3: ALU opcode; same encoding as `alu` (000 add … 111 shr).
- `cmd_a`, input, 8: operand A.
- `cmd_b`, input, 8: operand B.
- `cmd_acc`, input, 1: 1 = replace operand A with `acc` at issue time.
- `alu_op`, output, 3: drives `alu.op`.
- `alu_a`, output, 8: drives `alu.a`.
- `alu_b`, output, 8: drives `alu.b`.
- `alu_result`, input, 8: from `alu.result`.
- `alu_carry`, input, 1: from `alu.carry`.
- `rsp_valid`, output, 1: response register holds a result.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_result`, output, 8: registered result.
- `rsp_carry`, output, 1: registered carry (add: carry-out; sub: borrow, 1 when a < b; other ops: 0).
- `rsp_zero`, output, 1: registered; 1 when result == 0x00.
- `rsp_neg`, output, 1: registered; equals result[7].
- `acc`, output, 8: result of the most recently issued command.
- `count`, output, log2(DEPTH)+1: number of FIFO entries in use.

## Operation
- Push: when `cmd_valid && cmd_ready`, store `{op, a, b, acc_sel}` at the tail. `cmd_ready = (count < DEPTH)`. It is a pure function of the stored count and never depends on a same-cycle pop.
- Issue condition: `issue = (count != 0) && (!rsp_valid || rsp_ready)`.
- ALU drive (combinational from FIFO head):
  - `alu_op` = head.op; `alu_b` = head.b.
  - `alu_a` = head.acc_sel ? `acc` : head.a.
  - When count == 0, all `alu_*` outputs drive 0.
- On an issue edge:
  - pop the head;
  - load `rsp_result`, `rsp_carry`, `rsp_zero` and `rsp_neg` from `alu_result`/`alu_carry`;
  - set `rsp_valid` = 1;
  - load `acc` from `alu_result`.
- Response drain: when `rsp_valid && rsp_ready` and there is no issue, clear `rsp_valid`. Response data holds its last value.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full + consumer stalled: `cmd_ready` = 0 and the FIFO holds. No command is lost or reordered.
- Empty: a pushed command is not bypassed; it sits in the FIFO for one edge before issue.
- Pointers wrap modulo DEPTH. Count tracks occupancy 0..DEPTH exactly.
- Accumulator chaining: `acc` updates on the same edge as issue, so back-to-back `cmd_acc` commands see the previous result with no bubble.
- Reset (any time, including mid-stream): asynchronously clear the FIFO, pointers, `count`, `acc`, `rsp_valid` and all response data. Queued and pending work is discarded.

## Timing
- Reset values:
  - `cmd_ready` = 1, `rsp_valid` = 0, `count` = 0.
  - `acc`, `rsp_result`, `rsp_carry`, `rsp_zero`, `rsp_neg` = 0.
  - `alu_*` = 0.
- Latency: a command accepted at edge N issues at edge N+1 (if the response register is free). `rsp_valid` is high after edge N+1.
- Throughput: one command per cycle sustained while `rsp_ready` = 1.
- `rsp_*` outputs are stable while `rsp_valid && !rsp_ready`.
- The path `alu_*` → `alu` → `alu_result` is a single-cycle combinational path into the response registers.

## Test plan
- Reset: hold `rst_n` = 0 → `cmd_ready` = 1, `rsp_valid` = 0, `count` = 0, `acc` = 0x00. Release; idle 5 cycles → no `rsp_valid`.
- Add with carry: op 000, a = 0xF0, b = 0x20 at edge N → at N+1 `rsp_valid` = 1, result 0x10, carry 1, zero 0, neg 0; `acc` = 0x10.
- Subtract with borrow: op 001, a = 0x05, b = 0x07 → result 0xFE, carry 1, neg 1, zero 0. Then a = 0x07, b = 0x07 → result 0x00, carry 0, zero 1.
- Backpressure (DEPTH = 4): `rsp_ready` = 0, offer 6 commands back-to-back → 5 accepted (1 in response register, 4 in FIFO), `cmd_ready` = 0 with `count` = 4. Raise `rsp_ready` → 5 responses in order, one per cycle, then `cmd_ready` = 1.
- Accumulator chain: add a = 0x01, b = 0x01 (`cmd_acc` = 0), then three adds with `cmd_acc` = 1, b = 0x01 → responses 0x02, 0x03, 0x04, 0x05 on consecutive cycles; final `acc` = 0x05.
- Reset mid-stream: 3 commands queued, response pending. Pulse `rst_n` low asynchronously between edges → outputs clear immediately. After release, no response is emitted and `count` = 0.
